// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC register, imem request FSM, decode handshake
//
// Purpose: fetches one instruction word per handshake from instruction memory,
// holds it for decode until accepted, then advances the PC (sequential,
// branch or jump).
//
// Optional feature macro: FETCH_PERF_EN (adds saturating fetch_count/wait_count)
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset
//   imem_req       out  instruction-memory read request (FETCH state)
//   imem_addr      out  byte address of requested word (= pc)
//   imem_ack       in   read data valid this cycle
//   imem_rdata     in   instruction word
//   instr          out  held instruction for decode
//   op             out  instr[31:27]
//   instr_valid    out  instr/op valid (HOLD state)
//   instr_ready    in   decode accepts current instruction
//   pcsrc          in   branch taken
//   jump           in   jump decoded for current instruction
//   branch_target  in   taken-branch address
//   pc             out  address of current/pending instruction
//   fetch_count    out  handshakes seen (FETCH_PERF_EN only)
//   wait_count     out  FETCH cycles without ack (FETCH_PERF_EN only)

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          WIDTH    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic [4:0]       op,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             pcsrc,
    input  logic             jump,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      fetch_count,
    output logic [31:0]      wait_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;

    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] next_pc;
    logic             handshake;

    // pc + 4 wraps naturally at the 32-bit boundary
    assign pc_plus4    = pc_q + 32'd4;
    assign jump_target = {pc_plus4[31:29], instr_q[26:0], 2'b00};
    assign handshake   = (state_q == HOLD) && instr_ready;

    // jump wins over a taken branch
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (pcsrc) begin
            next_pc = branch_target;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign op          = instr_q[31:27];
    assign instr_valid = (state_q == HOLD);

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] wait_count_q, wait_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        wait_count_d  = wait_count_q;
        if (handshake && (fetch_count_q != 32'hFFFF_FFFF)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if ((state_q == FETCH) && !imem_ack && (wait_count_q != 32'hFFFF_FFFF)) begin
            wait_count_d = wait_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= '0;
            wait_count_q  <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            wait_count_q  <= wait_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign wait_count  = wait_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with behavioural model

module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT (RESET_PC = 0)
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [4:0]  op;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        pcsrc = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] pc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, wait_count;
`endif

    // second DUT (RESET_PC = 0xFFFF_FFFC) for the wrap case
    logic        r1_reset = 1'b1;
    logic        r1_req;
    logic [31:0] r1_addr;
    logic        r1_ack = 1'b0;
    logic [31:0] r1_instr;
    logic [4:0]  r1_op;
    logic        r1_valid;
    logic        r1_ready = 1'b0;
    logic [31:0] r1_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] r1_fc, r1_wc;
`endif

    fetch_stage #(.RESET_PC(32'h0000_0000), .WIDTH(32)) dut0 (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .op(op), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pcsrc(pcsrc), .jump(jump),
        .branch_target(branch_target), .pc(pc)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count), .wait_count(wait_count)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .WIDTH(32)) dut1 (
        .clk(clk), .reset(r1_reset),
        .imem_req(r1_req), .imem_addr(r1_addr),
        .imem_ack(r1_ack), .imem_rdata(32'h0000_0000),
        .instr(r1_instr), .op(r1_op), .instr_valid(r1_valid),
        .instr_ready(r1_ready), .pcsrc(1'b0), .jump(1'b0),
        .branch_target(32'h0000_0000), .pc(r1_pc)
`ifdef FETCH_PERF_EN
        , .fetch_count(r1_fc), .wait_count(r1_wc)
`endif
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: "running" = out of reset idle, "holding" = an
    // instruction is waiting for decode.
    logic [31:0] m_pc = '0, m_instr = '0, m_fc = '0, m_wc = '0;
    bit          m_run = 1'b0, m_hold = 1'b0;

    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                               input logic j, input logic b, input logic [31:0] bt);
        logic [31:0] seq;
        seq = cur + 32'd4;
        if (j)      return (seq & 32'hE000_0000) | ((ins & 32'h07FF_FFFF) << 2);
        else if (b) return bt;
        else        return seq;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_pc <= 32'h0; m_instr <= '0; m_run <= 1'b0; m_hold <= 1'b0;
            m_fc <= '0; m_wc <= '0;
        end else if (!m_run) begin
            m_run <= 1'b1;
        end else if (!m_hold) begin
            if (imem_ack) begin
                m_instr <= imem_rdata;
                m_hold  <= 1'b1;
            end else if (m_wc != 32'hFFFF_FFFF) begin
                m_wc <= m_wc + 1;
            end
        end else if (instr_ready) begin
            m_pc   <= model_next(m_pc, m_instr, jump, pcsrc, branch_target);
            m_hold <= 1'b0;
            if (m_fc != 32'hFFFF_FFFF) m_fc <= m_fc + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_req",   {31'd0, imem_req},    {31'd0, m_run && !m_hold});
            chk("m_valid", {31'd0, instr_valid}, {31'd0, m_hold});
            chk("m_addr",  imem_addr,            m_pc);
            chk("m_pc",    pc,                   m_pc);
            chk("m_instr", instr,                m_instr);
            chk("m_op",    {27'd0, op},          {27'd0, m_instr[31:27]});
`ifdef FETCH_PERF_EN
            chk("m_fetch_count", fetch_count, m_fc);
            chk("m_wait_count",  wait_count,  m_wc);
`endif
        end
    end

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc",    pc,                   32'h0);
        chk("rst_instr", instr,                32'h0);
        cmp_en = 1'b1;
        reset  = 1'b0;

        // first fetch, immediate ack
        @(negedge clk);
        chk("first_req",  {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr,         32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h0800_0000;
        @(negedge clk);
        chk("first_valid", {31'd0, instr_valid}, 32'd1);
        chk("first_op",    {27'd0, op},          32'h01);
        chk("hold_req",    {31'd0, imem_req},    32'd0);
        imem_ack = 1'b0; instr_ready = 1'b1;

        // sequential handshakes
        @(negedge clk);
        chk("seq_addr4", imem_addr, 32'h4);
        instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0;
        @(negedge clk);
        imem_ack = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        chk("seq_addr8", imem_addr, 32'h8);
        instr_ready = 1'b0;

        // jump to 0x100, then jump-over-branch and branch from 0x100
        imem_ack = 1'b1; imem_rdata = 32'h0000_0040;
        @(negedge clk);
        imem_ack = 1'b0; instr_ready = 1'b1; jump = 1'b1;
        @(negedge clk);
        chk("jmp_to_100", imem_addr, 32'h100);
        instr_ready = 1'b0; jump = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0010;
        @(negedge clk);
        imem_ack = 1'b0; instr_ready = 1'b1; jump = 1'b1; pcsrc = 1'b1; branch_target = 32'h80;
        @(negedge clk);
        chk("jump_prio", imem_addr, 32'h40);
        instr_ready = 1'b0; jump = 1'b0; pcsrc = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0040;
        @(negedge clk);
        imem_ack = 1'b0; instr_ready = 1'b1; jump = 1'b1;
        @(negedge clk);
        chk("jmp_to_100b", imem_addr, 32'h100);
        instr_ready = 1'b0; jump = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0000_0010;
        @(negedge clk);
        imem_ack = 1'b0; instr_ready = 1'b1; pcsrc = 1'b1; branch_target = 32'h80;
        @(negedge clk);
        chk("branch", imem_addr, 32'h80);
        instr_ready = 1'b0; pcsrc = 1'b0;

        // stall in HOLD for 5 cycles; stray acks must be ignored
        imem_ack = 1'b1; imem_rdata = 32'hA5A5_0000;
        @(negedge clk);
        imem_rdata = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_instr", instr, 32'hA5A5_0000);
            chk("stall_pc",    pc,    32'h80);
            chk("stall_req",   {31'd0, imem_req},    32'd0);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        imem_ack = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_req",   {31'd0, imem_req},    32'd1);
        chk("stall_release_valid", {31'd0, instr_valid}, 32'd0);
        instr_ready = 1'b0;

        // reset during FETCH with ack pending; late ack ignored
        imem_ack = 1'b1; reset = 1'b1;
        @(negedge clk);
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_pc",  pc,                32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("late_ack_req",   {31'd0, imem_req},    32'd1);
        chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);

        // ack delayed three FETCH cycles, then one handshake
        imem_ack = 1'b0;
        repeat (3) @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'h0;
        @(negedge clk);
        imem_ack = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        chk("delay_req", {31'd0, imem_req}, 32'd1);
`ifdef FETCH_PERF_EN
        chk("perf_wait",  wait_count,  32'd3);
        chk("perf_fetch", fetch_count, 32'd1);
`endif
        instr_ready = 1'b0;

        // PC wrap on the second instance
        r1_reset = 1'b0;
        @(negedge clk);
        chk("wrap_first_addr", r1_addr, 32'hFFFF_FFFC);
        chk("wrap_first_req",  {31'd0, r1_req}, 32'd1);
        r1_ack = 1'b1;
        @(negedge clk);
        r1_ack = 1'b0; r1_ready = 1'b1;
        @(negedge clk);
        chk("wrap_addr", r1_addr, 32'h0);
        chk("wrap_req",  {31'd0, r1_req}, 32'd1);
        r1_ready = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset         = ($urandom_range(0, 99) == 0);
            imem_ack      = ($urandom_range(0, 1) == 1);
            imem_rdata    = $urandom;
            instr_ready   = ($urandom_range(0, 4) < 2);
            pcsrc         = ($urandom_range(0, 2) == 0);
            jump          = ($urandom_range(0, 3) == 0);
            branch_target = $urandom & 32'hFFFF_FFFC;
        end
        @(negedge clk);
        reset = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        @(negedge clk);
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 SHALL have parameter WIDTH, default 32: instruction, address and target width; fixed at 32.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 SHALL provide: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide: imem_req  output  1  instruction-memory read request.
REQ-006 SHALL provide: imem_addr  output  32  byte address of the requested word (= pc).
REQ-007 SHALL provide: imem_ack  input  1  read data valid this cycle.
REQ-008 SHALL provide: imem_rdata  input  32  instruction word.
REQ-009 SHALL provide: instr  output  32  held instruction for decode.
REQ-010 SHALL provide: op  output  5  instr[31:27], feeds the controller opcode input.
REQ-011 SHALL provide: instr_valid  output  1  instr/op valid.
REQ-012 SHALL provide: instr_ready  input  1  decode/execute accepts current instruction.
REQ-013 SHALL provide: pcsrc  input  1  branch taken (controller branch AND zero).
REQ-014 SHALL provide: jump  input  1  jump decoded for current instruction.
REQ-015 SHALL provide: branch_target  input  32  taken-branch address.
REQ-016 SHALL provide: pc  output  32  address of current/pending instruction.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, HOLD.
REQ-018 SHALL move IDLE -> FETCH unconditionally on the first clock after reset deasserts.
REQ-019 SHALL, in FETCH, drive imem_req=1 and imem_addr=pc, both stable until imem_ack.
REQ-020 SHALL, on imem_ack in FETCH, register imem_rdata into instr and enter HOLD; instr_valid=1 from the next cycle (1-cycle latency).
REQ-021 SHALL ignore imem_ack outside FETCH and instr_ready outside HOLD.
REQ-022 SHALL, in HOLD, keep imem_req=0 and hold instr, op, pc and instr_valid=1 while instr_ready=0.
REQ-023 SHALL, on instr_ready=1 in HOLD (handshake), load pc with the next PC, enter FETCH, and drop instr_valid on the next cycle.
REQ-024 SHALL compute the next PC as: jump=1 -> {pc+4[31:29], instr[26:0], 2'b00}; else pcsrc=1 -> branch_target; else pc+4. jump has priority over pcsrc.
REQ-025 SHALL sample pcsrc, jump and branch_target only in the handshake cycle.
REQ-026 SHALL compute pc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-027 SHALL drive op combinationally from instr[31:27] at all times.

Reset
REQ-028 SHALL, while reset=1, set state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, regardless of state (mid-fetch request abandoned; a late imem_ack is ignored).
REQ-029 SHALL take priority for reset over all other inputs in the same cycle.

Configuration
REQ-030 SHALL, when macro FETCH_PERF_EN is defined, add outputs fetch_count (32) counting handshakes and wait_count (32) counting FETCH cycles with imem_ack=0; both saturating, cleared by reset.
REQ-031 SHALL, without FETCH_PERF_EN, omit those ports and counters; all other behaviour identical.

Verification
REQ-032 Reset, then imem_ack=1 with rdata 0x0800_0000 on the first FETCH cycle -> first req at addr 0x0; next cycle instr_valid=1, op=5'h01.
REQ-033 Three handshakes with pcsrc=jump=0, ack immediate -> imem_addr sequence 0x0, 0x4, 0x8.
REQ-034 At pc=0x100 with instr=0x0000_0010, jump=1, pcsrc=1, branch_target=0x80 -> next imem_addr=0x40; repeat with jump=0 -> 0x80.
REQ-035 instr_ready held 0 for 5 cycles in HOLD -> instr, pc constant, imem_req=0 throughout; handshake on cycle 6 -> FETCH next cycle.
REQ-036 Reset asserted during FETCH with ack pending -> imem_req=0 next cycle, pc=RESET_PC; RESET_PC=0xFFFF_FFFC plus one sequential handshake -> imem_addr=0x0.
REQ-037 With FETCH_PERF_EN, ack delayed 3 cycles then one handshake -> wait_count=3, fetch_count=1.
